// File: rtl/text_stream_ctrl.sv
// text_stream_ctrl
// Owns the address port of a 256x8 text memory. On start it scans from
// address 0 to find the message length (first TERM_CHAR, or all 256 bytes),
// then walks the same addresses again and streams each character over a
// valid/ready handshake.
// Optional build macro: TEXT_UPPER_FOLD_EN folds 'a'..'z' to 'A'..'Z' on the
// way out; scan and length behaviour do not change.
module text_stream_ctrl #(
  parameter logic [7:0] TERM_CHAR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_din,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       char_last,
  output logic [8:0] msg_len,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] char_q, char_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic [8:0] len_q, len_d;
  logic [8:0] fcnt_q, fcnt_d;
  logic [7:0] fold_char;
  logic       slot_free;

`ifdef TEXT_UPPER_FOLD_EN
  // Lower-case letters lose bit 5; every other byte passes unchanged.
  assign fold_char = (mem_din >= 8'h61 && mem_din <= 8'h7A) ? (mem_din & 8'hDF) : mem_din;
`else
  assign fold_char = mem_din;
`endif

  // The output register can take a new character when empty or being drained.
  assign slot_free = !valid_q || char_ready;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 8'd0;
      char_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      len_q   <= 9'd0;
      fcnt_q  <= 9'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      len_q   <= len_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state logic: scan pass, then stream pass over the same addresses.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    char_d  = char_q;
    valid_d = valid_q;
    last_d  = last_q;
    len_d   = len_q;
    fcnt_d  = fcnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = 9'd0;
          addr_d  = 8'd0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (mem_din == TERM_CHAR) begin
          len_d   = {1'b0, addr_q};
          addr_d  = 8'd0;
          fcnt_d  = 9'd0;
          state_d = S_STREAM;
        end else if (addr_q == 8'hFF) begin
          // No terminator anywhere: the whole memory is the message.
          len_d   = 9'd256;
          addr_d  = 8'd0;
          fcnt_d  = 9'd0;
          state_d = S_STREAM;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end

      S_STREAM: begin
        if (fcnt_q == len_q && slot_free) begin
          // Everything fetched and the last character (if any) accepted.
          // With an empty message this fires on the first STREAM cycle.
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end else if (fcnt_q < len_q && slot_free) begin
          char_d  = fold_char;
          valid_d = 1'b1;
          last_d  = (fcnt_q == len_q - 9'd1);
          fcnt_d  = fcnt_q + 9'd1;
          addr_d  = addr_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr   = addr_q;
  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign char_last  = last_q;
  assign msg_len    = len_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_text_stream_ctrl.sv
// Self-checking bench for text_stream_ctrl. A behavioural model derives the
// expected length, character list and latency straight from the memory image;
// a per-cycle checker compares the stream against it, and directed runs add
// literal expectations for the basic scenarios.
`timescale 1ns/1ps
module tb_text_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready = 1'b1;
  logic       char_last;
  logic [8:0] msg_len;
  logic       busy;
  logic       done;

  text_stream_ctrl #(.TERM_CHAR(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_last  (char_last),
    .msg_len    (msg_len),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  assign mem_din = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q[$];
  int         exp_len = 0;
  int         exp_cyc = 0;
  bit         armed = 0;
  int         run_id = 0;

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef TEXT_UPPER_FOLD_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic build_model();
    int len;
    len = 256;
    for (int i = 255; i >= 0; i--) if (mem[i] == 8'h00) len = i;
    exp_len = len;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(fold(mem[i]));
    // start cycle + scan + one cycle per character + done cycle
    exp_cyc = 1 + ((len < 256) ? len + 1 : 256) + len + 1;
  endtask

  task automatic load_mem(input string s, input logic [7:0] fill, input bit term);
    for (int i = 0; i < 256; i++) mem[i] = fill;
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    if (term && s.len() < 256) mem[s.len()] = 8'h00;
  endtask

  // ---------------- ready pattern driver ----------------
  bit pat[$];
  bit pat_go = 0;
  always @(posedge clk) begin
    #1;
    if (pat.size() > 0 && (pat_go || char_valid)) begin
      pat_go = 1;
      char_ready = pat.pop_front();
    end else begin
      pat_go = 0;
      char_ready = 1'b1;
    end
  end

  // ---------------- per-cycle compare process ----------------
  int         seen_run = -1;
  int         idx = 0;
  int         done_cnt = 0;
  logic [7:0] recv[$];
  bit         prev_stall = 0;
  logic [7:0] prev_char = 8'd0;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    if (rst || !armed) begin
      prev_stall = 0;
    end else begin
      if (run_id != seen_run) begin
        seen_run   = run_id;
        idx        = 0;
        done_cnt   = 0;
        prev_stall = 0;
        recv.delete();
      end
      if (prev_stall) begin
        check("stall_valid", int'(char_valid), 1);
        check("stall_char", int'(char_out), int'(prev_char));
        check("stall_last", int'(char_last), int'(prev_last));
      end
      if (char_valid) begin
        if (idx < exp_len) begin
          check("char", int'(char_out), int'(exp_q[idx]));
          check("last", int'(char_last), int'(idx == exp_len - 1));
        end else begin
          check("extra_char", idx, exp_len);
        end
        if (char_ready) begin
          recv.push_back(char_out);
          idx++;
        end
      end else begin
        check("last_without_valid", int'(char_last), 0);
      end
      prev_stall = char_valid && !char_ready;
      prev_char  = char_out;
      prev_last  = char_last;
      if (done) begin
        done_cnt++;
        check("done_msg_len", int'(msg_len), exp_len);
        check("done_delivered", idx, exp_len);
        check("done_busy", int'(busy), 1);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check_reset(input string tag);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_char_out"}, int'(char_out), 0);
    check({tag, "_char_valid"}, int'(char_valid), 0);
    check({tag, "_char_last"}, int'(char_last), 0);
    check({tag, "_msg_len"}, int'(msg_len), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // Runs one message; optionally pulses start at a cycle offset, or aborts
  // with a one-cycle reset at a cycle offset.
  task automatic run(input string name, input int tmo, input int start_at,
                     input int rst_at, input bit chk_time);
    int t0;
    bit got;
    run_id++;
    build_model();
    armed = 1;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    while (cyc - t0 <= tmo) begin
      if (done) begin
        got = 1;
        break;
      end
      if (rst_at > 0 && cyc - t0 == rst_at) begin
        armed = 0;
        rst = 1'b1;
        @(negedge clk);
        check_reset({name, "_abort"});
        rst = 1'b0;
        $display("RUN %s aborted by reset at cycle %0d", name, rst_at);
        return;
      end
      @(negedge clk);
      start = (start_at > 0 && cyc - t0 == start_at);
    end
    start = 1'b0;
    check({name, "_done_seen"}, int'(got), 1);
    if (chk_time) check({name, "_cycles"}, cyc - t0, exp_cyc);
    @(negedge clk);
    @(negedge clk);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_recv_count"}, recv.size(), exp_len);
    check({name, "_msg_len_hold"}, int'(msg_len), exp_len);
    $display("RUN %s len=%0d chars=%0d cycles=%0d", name, int'(msg_len), recv.size(), cyc - t0 - 2);
  endtask

  logic [7:0] lit_a, lit_b;

  initial begin
`ifdef TEXT_UPPER_FOLD_EN
    lit_a = 8'h41;
    lit_b = 8'h42;
`else
    lit_a = 8'h61;
    lit_b = 8'h62;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // "HI\0" with ready held high
    load_mem("HI", 8'h5A, 1);
    run("hi", 40, 0, 0, 1);
    check("hi_msg_len", int'(msg_len), 2);
    check("hi_model_cycles", exp_cyc, 7);
    check("hi_char0", int'(recv[0]), 8'h48);
    check("hi_char1", int'(recv[1]), 8'h49);

    // empty message
    load_mem("", 8'h33, 1);
    run("empty", 40, 0, 0, 1);
    check("empty_msg_len", int'(msg_len), 0);
    check("empty_no_chars", recv.size(), 0);

    // no terminator: whole memory is the message
    load_mem("", 8'h41, 0);
    run("full", 700, 0, 0, 1);
    check("full_msg_len", int'(msg_len), 256);
    check("full_model_cycles", exp_cyc, 514);

    // "ab\0" with ready toggling 0,0,1,0,1 once valid appears
    load_mem("ab", 8'h7E, 1);
    pat.delete();
    pat.push_back(1'b0);
    pat.push_back(1'b0);
    pat.push_back(1'b1);
    pat.push_back(1'b0);
    pat.push_back(1'b1);
    run("ab_stall", 60, 0, 0, 0);
    check("ab_char0", int'(recv[0]), int'(lit_a));
    check("ab_char1", int'(recv[1]), int'(lit_b));

    // start pulsed mid-stream must be ignored
    load_mem("Hello", 8'h2E, 1);
    run("start_ignored", 60, 9, 0, 1);
    check("start_ignored_len", int'(msg_len), 5);

    // reset mid-stream, then a fresh scan from address 0
    load_mem("Hello", 8'h2E, 1);
    run("rst_mid", 60, 0, 9, 0);
    load_mem("Ok", 8'h2E, 1);
    run("after_rst", 60, 0, 0, 1);
    check("after_rst_len", int'(msg_len), 2);
    check("after_rst_char0", int'(recv[0]), int'(fold(8'h4F)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_stream_ctrl.md
# text_stream_ctrl

Sequencer that owns the address port of the 256×8 text memory. On `start` it scans memory from address 0 to find the message length (first 0x00 byte, or all 256 bytes), then re-walks the same addresses and streams each character to the braille converter over a valid/ready handshake. It replaces free-running address generation in the size calculator with one controller that serialises the two passes over the shared read port.

## Interface
Parameters:
- `TERM_CHAR`, 8'h00: terminator byte that ends the scan; it is never streamed.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin; sampled only in IDLE.
- `mem_addr`  out  8  address to text memory; registered.
- `mem_din`  in  8  memory read data; combinational from `mem_addr`, valid the same cycle.
- `char_out`  out  8  streamed character; registered.
- `char_valid`  out  1  `char_out` holds a character.
- `char_ready`  in  1  downstream accepts `char_out` this cycle.
- `char_last`  out  1  qualifies `char_out` as the final character; valid only with `char_valid`.
- `msg_len`  out  9  scanned length, 0..256; holds until next `start`.
- `busy`  out  1  high in SCAN, STREAM or DONE.
- `done`  out  1  one-cycle pulse when the message is fully delivered.

## Operation
- Reset values: state IDLE; `mem_addr` 0; `char_out` 0; `char_valid` 0; `char_last` 0; `msg_len` 0; `busy` 0; `done` 0.
- **IDLE**
  - `start`=1: clear `msg_len`, set `mem_addr`=0, go to SCAN.
  - All other inputs are ignored.
- **SCAN**: each cycle, examine `mem_din`.
  - If `mem_din`==`TERM_CHAR`: `msg_len`←`mem_addr` (zero-extended), `mem_addr`←0, go to STREAM.
  - Else if `mem_addr`==255: `msg_len`←256, `mem_addr`←0, go to STREAM (no wrap-around scan).
  - Else: `mem_addr`++.
- **STREAM**: internal 9-bit fetch count `fcnt`, cleared on entry.
  - Load condition: `fcnt` < `msg_len` and (`char_valid`=0 or `char_ready`=1).
  - On load: `char_out`←`mem_din`; `char_valid`←1; `char_last`←(`fcnt`==`msg_len`−1); `fcnt`++; `mem_addr`++ (8-bit, wraps 255→0 only after the 256th fetch, value then unused).
  - If `char_valid`&&`char_ready`&&`fcnt`==`msg_len`: clear `char_valid`/`char_last`, go to DONE.
  - `msg_len`==0: go directly to DONE on the first STREAM cycle; nothing is streamed.
  - While `char_valid`=1 and `char_ready`=0: `char_out`, `char_last` and `mem_addr` hold stable.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE.
- `start` asserted outside IDLE is ignored (no queuing).
- `rst` at any point aborts the operation; all outputs take reset values on the next edge.

## Timing
- SCAN takes `msg_len`+1 cycles when a terminator is present, and 256 cycles when it is absent.
- First `char_valid` appears 1 cycle after entering STREAM.
- Throughput is 1 char/cycle with `char_ready` held high.
- `done` rises 1 cycle after the last handshake; `busy` falls together with `done`.
- Total for length L with ready held high: 1 (start) + (L+1) scan + L stream + 1 done cycle.

## Configuration
- `TEXT_UPPER_FOLD_EN`
  - Defined: during the STREAM load, bytes 0x61–0x7A are converted to 0x41–0x5A (bit 5 cleared). All other bytes pass unchanged.
  - Undefined: bytes pass through verbatim.
  - Scan and length behaviour are identical either way.

## Test plan
- Memory "HI\0", `char_ready`=1, `start` → `msg_len`=2; `char_out` 0x48 then 0x49, with `char_last` on 0x49; `done` pulse; exact cycle count 7 from `start`.
- Memory byte0=0x00, `start` → `msg_len`=0; `char_valid` never rises; `done` pulses; back in IDLE.
- All 256 bytes 0x41 → `msg_len`=256; 256 transfers; `char_last` only on the 256th; `mem_addr` does not rescan.
- "ab\0" with `char_ready` toggling 0,0,1,0,1 → `char_out` stable while stalled; order a,b preserved; 0x41/0x42 with `TEXT_UPPER_FOLD_EN`, 0x61/0x62 without.
- `start` pulsed during STREAM → ignored; output sequence and `msg_len` unchanged.
- `rst` asserted mid-STREAM for 1 cycle → next cycle all outputs at reset values, state IDLE; a new `start` rescans from address 0.
